// File: rtl/pipeexe_md_if.sv
// pipeexe_md_if: operand/control bundle between the D/E pipeline register
// and the execute stage, plus the execute-stage results.
//   master : D/E register side (drives operands and controls, reads results)
//   slave  : execute stage (reads operands and controls, drives results)
// Signals:
//   ea, eb   operand A/B          eimm     extended immediate (shamt in [10:6])
//   epc4     PC+4 of E-stage op   ealuc    ALU op
//   ealuimm  B = eimm             eshift   A = shamt
//   ejal     result = epc4+4      emdop    multiply/divide op
//   ealu     E-stage result       md_busy  iterative op in progress
//   stall    hold IF/ID/DE
interface pipeexe_md_if;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] eimm;
    logic [31:0] epc4;
    logic [3:0]  ealuc;
    logic        ealuimm;
    logic        eshift;
    logic        ejal;
    logic [2:0]  emdop;
    logic [31:0] ealu;
    logic        md_busy;
    logic        stall;

    modport master (
        output ea, eb, eimm, epc4, ealuc, ealuimm, eshift, ejal, emdop,
        input  ealu, md_busy, stall
    );

    modport slave (
        input  ea, eb, eimm, epc4, ealuc, ealuimm, eshift, ejal, emdop,
        output ealu, md_busy, stall
    );
endinterface

// File: rtl/pipeexe_md.sv
// pipeexe_md: execute stage of the 5-stage pipeline. Single-cycle ALU plus an
// iterative multiply/divide unit holding HI/LO. While the unit is busy, any
// further md op or mfhi/mflo raises stall so the D/E register holds.
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous, active-high; clears HI/LO and the md FSM
//   ex      pipeexe_md_if.slave (operands/controls in, ealu/md_busy/stall out)
// Parameters:
//   MUL_BITS_PER_CYCLE  1 or 2 multiplier bits retired per cycle
// Build option:
//   MD_DIV_EN  defined: restoring divider for div/divu (emdop 3/4)
//              undefined: no divider; emdop 3/4 behave as no-ops
module pipeexe_md #(
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic          clock,
    input  logic          reset,
    pipeexe_md_if.slave   ex
);

    localparam int         MB      = (MUL_BITS_PER_CYCLE == 2) ? 2 : 1;
    localparam logic [5:0] MUL_CNT = 6'(32 / MB);
`ifdef MD_DIV_EN
    localparam logic [5:0] DIV_CNT = 6'd32;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DIV} md_state_t;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    function automatic logic [31:0] alu(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [3:0]  op);
        logic signed [31:0] bs;
        logic [31:0]        y;
        bs = b;
        casez (op)
            4'b?000: y = a + b;
            4'b?100: y = a - b;
            4'b?001: y = a & b;
            4'b?101: y = a | b;
            4'b?010: y = a ^ b;
            4'b?110: y = {b[15:0], 16'h0000};
            4'b0011: y = b << a[4:0];
            4'b0111: y = b >> a[4:0];
            4'b1111: y = 32'(bs >>> a[4:0]);
            default: y = 32'h0000_0000;
        endcase
        return y;
    endfunction

    // Control/state registers
    md_state_t   state;
    logic        busy_q;
    logic [5:0]  count_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    // Datapath registers: work_q is {acc, multiplier} for mult and
    // {remainder, dividend/quotient} for div; opm_q is multiplicand or divisor.
    logic [63:0] work_q;
    logic [31:0] opm_q;
    logic        neg_q;
`ifdef MD_DIV_EN
    logic        rneg_q;
    logic        dz_q;
    logic [31:0] dzval_q;
`endif

    // ALU and result select
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic [31:0] ealu_c;

    always_comb begin
        alu_a  = ex.eshift  ? {27'b0, ex.eimm[10:6]} : ex.ea;
        alu_b  = ex.ealuimm ? ex.eimm : ex.eb;
        alu_y  = alu(alu_a, alu_b, ex.ealuc);
        ealu_c = alu_y;
        if (ex.ejal)
            ealu_c = ex.epc4 + 32'd4;
        else if (ex.emdop == 3'd5)
            ealu_c = hi_q;
        else if (ex.emdop == 3'd6)
            ealu_c = lo_q;
    end

    // md op decode and operand magnitudes
    logic        op_mul;
    logic        op_div;
    logic        op_signed;
    logic        op_mf;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        stall_c;

    always_comb begin
        op_mul    = (ex.emdop == 3'd1) || (ex.emdop == 3'd2);
`ifdef MD_DIV_EN
        op_div    = (ex.emdop == 3'd3) || (ex.emdop == 3'd4);
`else
        op_div    = 1'b0;
`endif
        op_signed = (ex.emdop == 3'd1) || (ex.emdop == 3'd3);
        op_mf     = (ex.emdop == 3'd5) || (ex.emdop == 3'd6);
        mag_a     = (op_signed && ex.ea[31]) ? neg32(ex.ea) : ex.ea;
        mag_b     = (op_signed && ex.eb[31]) ? neg32(ex.eb) : ex.eb;
        // Without the divider, div/divu never stall.
        stall_c   = busy_q && (op_mul || op_div || op_mf);
    end

    // One multiply step: add multiplicand * low digit to the accumulator,
    // then shift the {acc, multiplier} pair right by the digit width.
    logic [1:0]  digit;
    logic [33:0] addend;
    logic [33:0] upper;
    logic [65:0] wide;
    logic [63:0] mul_nxt;
    logic [63:0] prod_fin;

    always_comb begin
        digit    = (MB == 2) ? work_q[1:0] : {1'b0, work_q[0]};
        addend   = (digit[0] ? {2'b00, opm_q} : 34'd0)
                 + (digit[1] ? {1'b0, opm_q, 1'b0} : 34'd0);
        upper    = {2'b00, work_q[63:32]} + addend;
        wide     = {upper, work_q[31:0]};
        mul_nxt  = (MB == 2) ? wide[65:2] : wide[64:1];
        prod_fin = neg_q ? neg64(mul_nxt) : mul_nxt;
    end

`ifdef MD_DIV_EN
    // One restoring divide step. The remainder stays below the divisor, so
    // a 33-bit trial subtraction is enough; a zero divisor naturally yields
    // an all-ones quotient but is overridden at completion anyway.
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [63:0] div_nxt;
    logic [31:0] quot_fin;
    logic [31:0] rem_fin;

    always_comb begin
        shifted  = work_q[63:31];
        diff     = shifted - {1'b0, opm_q};
        div_nxt  = diff[32] ? {shifted[31:0], work_q[30:0], 1'b0}
                            : {diff[31:0],    work_q[30:0], 1'b1};
        quot_fin = dz_q ? 32'hFFFF_FFFF
                        : (neg_q ? neg32(div_nxt[31:0]) : div_nxt[31:0]);
        rem_fin  = dz_q ? dzval_q
                        : (rneg_q ? neg32(div_nxt[63:32]) : div_nxt[63:32]);
    end
`endif

    // md FSM: starts only from IDLE, finishes on the edge where count hits 1
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            count_q <= 6'd0;
            hi_q    <= 32'h0;
            lo_q    <= 32'h0;
            work_q  <= 64'h0;
            opm_q   <= 32'h0;
            neg_q   <= 1'b0;
`ifdef MD_DIV_EN
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            dzval_q <= 32'h0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (op_mul) begin
                        state   <= MUL;
                        busy_q  <= 1'b1;
                        count_q <= MUL_CNT;
                        work_q  <= {32'h0, mag_b};
                        opm_q   <= mag_a;
                        neg_q   <= op_signed && (ex.ea[31] ^ ex.eb[31]);
                    end
`ifdef MD_DIV_EN
                    else if (op_div) begin
                        state   <= DIV;
                        busy_q  <= 1'b1;
                        count_q <= DIV_CNT;
                        work_q  <= {32'h0, mag_a};
                        opm_q   <= mag_b;
                        neg_q   <= op_signed && (ex.ea[31] ^ ex.eb[31]);
                        rneg_q  <= op_signed && ex.ea[31];
                        dz_q    <= (ex.eb == 32'h0);
                        dzval_q <= ex.ea;
                    end
`endif
                end
                MUL: begin
                    work_q  <= mul_nxt;
                    count_q <= count_q - 6'd1;
                    if (count_q == 6'd1) begin
                        hi_q   <= prod_fin[63:32];
                        lo_q   <= prod_fin[31:0];
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
`ifdef MD_DIV_EN
                DIV: begin
                    work_q  <= div_nxt;
                    count_q <= count_q - 6'd1;
                    if (count_q == 6'd1) begin
                        hi_q   <= rem_fin;
                        lo_q   <= quot_fin;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
`endif
                default: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    count_q <= 6'd0;
                end
            endcase
        end
    end

    assign ex.ealu    = ealu_c;
    assign ex.md_busy = busy_q;
    assign ex.stall   = stall_c;

endmodule

// File: tb/tb_pipeexe_md.sv
module tb_pipeexe_md;

    localparam int MBPC     = 1;
    localparam int MUL_CYC  = 32 / MBPC;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    pipeexe_md_if ex ();

    pipeexe_md #(.MUL_BITS_PER_CYCLE(MBPC)) dut (
        .clock (clock),
        .reset (reset),
        .ex    (ex.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        ex.ea = 32'h0; ex.eb = 32'h0; ex.eimm = 32'h0; ex.epc4 = 32'h0;
        ex.ealuc = 4'b0000; ex.ealuimm = 1'b0; ex.eshift = 1'b0;
        ex.ejal = 1'b0; ex.emdop = 3'd0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait out a busy period with mflo presented; returns busy cycle count
    // and whether stall stayed high throughout.
    task automatic wait_busy(output int n, output logic held);
        n = 0;
        held = 1'b1;
        while (ex.md_busy === 1'b1 && n < 200) begin
            if (ex.stall !== 1'b1) held = 1'b0;
            tick();
            n++;
        end
    endtask

    // Issue one md op from IDLE, then present mflo behind it.
    task automatic run_md(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_cyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int   n;
        logic held;
        clear_in();
        ex.emdop = op; ex.ea = a; ex.eb = b;
        #1;
        chk({tag, "_start_stall"}, {31'b0, ex.stall}, 32'd0);
        tick();
        clear_in();
        ex.emdop = 3'd6;
        #1;
        wait_busy(n, held);
        chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_cyc));
        chk({tag, "_stall_held"}, {31'b0, held}, 32'd1);
        chk({tag, "_lo"}, ex.ealu, exp_lo);
        ex.emdop = 3'd5;
        #1;
        chk({tag, "_hi"}, ex.ealu, exp_hi);
    endtask

    initial begin
        int   n;
        logic held;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        clear_in();
        #1;
        chk("rst_busy", {31'b0, ex.md_busy}, 32'd0);
        chk("rst_stall", {31'b0, ex.stall}, 32'd0);
        ex.emdop = 3'd5;
        #1;
        chk("rst_hi", ex.ealu, 32'h0);
        ex.emdop = 3'd6;
        #1;
        chk("rst_lo", ex.ealu, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        clear_in();
        tick();

        // ALU
        ex.ea = 32'd5; ex.eb = 32'hFFFF_FFF9; ex.ealuc = 4'b0000;
        #1; chk("alu_add", ex.ealu, 32'hFFFF_FFFE);
        ex.ealuc = 4'b0100;
        #1; chk("alu_sub", ex.ealu, 32'h0000_000C);
        ex.ealuc = 4'b0010;
        #1; chk("alu_xor", ex.ealu, 32'hFFFF_FFFC);
        clear_in();
        ex.eshift = 1'b1; ex.eimm = 32'h0000_0100; ex.eb = 32'h8000_0000;
        ex.ealuc = 4'b1111;
        #1; chk("alu_sra", ex.ealu, 32'hF800_0000);
        ex.ealuc = 4'b0111;
        #1; chk("alu_srl", ex.ealu, 32'h0800_0000);
        clear_in();
        ex.ealuimm = 1'b1; ex.eimm = 32'h0000_1234; ex.ealuc = 4'b0110;
        #1; chk("alu_lui", ex.ealu, 32'h1234_0000);

        // jal
        clear_in();
        ex.ejal = 1'b1; ex.epc4 = 32'h0000_0104; ex.emdop = 3'd6;
        #1;
        chk("jal_ealu", ex.ealu, 32'h0000_0108);
        chk("jal_stall", {31'b0, ex.stall}, 32'd0);
        clear_in();
        tick();

        // mult -3 * 7 = -21
        run_md("mult", 3'd1, 32'hFFFF_FFFD, 32'd7, MUL_CYC, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        tick();

`ifdef MD_DIV_EN
        run_md("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        tick();
        run_md("divu0", 3'd4, 32'd9, 32'd0, 32, 32'd9, 32'hFFFF_FFFF);
        tick();
        run_md("divmin", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'h0, 32'h8000_0000);
        tick();
`else
        // div is a no-op: ALU result, no busy, HI/LO kept
        clear_in();
        ex.emdop = 3'd3; ex.ea = 32'hFFFF_FFF9; ex.eb = 32'd2;
        #1;
        chk("nodiv_ealu", ex.ealu, 32'hFFFF_FFFB);
        chk("nodiv_stall", {31'b0, ex.stall}, 32'd0);
        tick();
        chk("nodiv_busy", {31'b0, ex.md_busy}, 32'd0);
        ex.emdop = 3'd6;
        #1;
        chk("nodiv_lo", ex.ealu, 32'hFFFF_FFEB);
        tick();
`endif

        // Back-to-back: multu presented while a prior op is busy
        clear_in();
`ifdef MD_DIV_EN
        ex.emdop = 3'd4; ex.ea = 32'd100; ex.eb = 32'd7;
`else
        ex.emdop = 3'd1; ex.ea = 32'd100; ex.eb = 32'd7;
`endif
        tick();
        ex.emdop = 3'd2; ex.ea = 32'hFFFF_FFFF; ex.eb = 32'hFFFF_FFFF;
        #1;
        wait_busy(n, held);
        chk("b2b_stall_held", {31'b0, held}, 32'd1);
        chk("b2b_idle_stall", {31'b0, ex.stall}, 32'd0);
        tick();
        chk("b2b_started", {31'b0, ex.md_busy}, 32'd1);
        clear_in();
        ex.emdop = 3'd6;
        #1;
        wait_busy(n, held);
        chk("b2b_cycles", 32'(n), 32'(MUL_CYC));
        chk("b2b_lo", ex.ealu, 32'h0000_0001);
        ex.emdop = 3'd5;
        #1;
        chk("b2b_hi", ex.ealu, 32'hFFFF_FFFE);
        tick();

        // Reset during a mult
        clear_in();
        ex.emdop = 3'd2; ex.ea = 32'd3; ex.eb = 32'd5;
        tick();
        ex.emdop = 3'd6;
        for (int i = 0; i < 9; i++) tick();
        chk("mid_busy", {31'b0, ex.md_busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", {31'b0, ex.md_busy}, 32'd0);
        chk("arst_lo", ex.ealu, 32'h0);
        ex.emdop = 3'd5;
        #1;
        chk("arst_hi", ex.ealu, 32'h0);
        chk("arst_stall", {31'b0, ex.stall}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        #1;
        chk("post_rst_hi", ex.ealu, 32'h0);
        chk("post_rst_busy", {31'b0, ex.md_busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
